id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register; sits directly downstream of main_control and the register bank.
//  Captures the 14-bit control word, operand buses and instruction fields once per enabled cycle.
//  Presents them to the EX stage one cycle later.
//  Supports a global stall (debug-unit step/halt), bubble insertion (hazard unit flush) and a saturating bubble counter.
// PARAMETERS
//  BUS_SIZE   32  width of data buses (bus A/B, extended immediate)
//  PC_SIZE    32  width of program-counter values
//  CNT_SIZE   16  width of bubble counter
// PORTS
//  i_clk             in   1         system clock, rising edge
//  i_reset_n         in   1         asynchronous reset, active low
//  i_enable          in   1         1 = pipeline advances; 0 = hold every register (debug freeze)
//  i_flush           in   1         1 = load bubble instead of ID-stage contents
//  i_halt            in   1         HALT instruction decoded in ID
//  i_ctrl_regs       in   14        control word from main_control
//  i_bus_a           in   BUS_SIZE  register-bank read port A (rs)
//  i_bus_b           in   BUS_SIZE  register-bank read port B (rt)
//  i_inm_ext         in   BUS_SIZE  immediate, already extended per alu_src
//  i_next_seq_pc     in   PC_SIZE   PC+4 of instruction in ID (JAL/JALR link value)
//  i_rs,i_rt,i_rd    in   5 each    register indices
//  i_shamt           in   5         shift amount
//  i_funct           in   6         funct field
//  o_ctrl_regs       out  14        registered control word
//  o_bus_a,o_bus_b   out  BUS_SIZE  registered operands
//  o_inm_ext         out  BUS_SIZE  registered immediate
//  o_next_seq_pc     out  PC_SIZE   registered link value
//  o_rs,o_rt,o_rd    out  5 each    registered indices (forwarding-unit compare)
//  o_shamt           out  5         registered shift amount
//  o_funct           out  6         registered funct
//  o_valid           out  1         1 = real instruction in EX, 0 = bubble/reset
//  o_halt            out  1         registered halt flag
//  o_bubble_count    out  CNT_SIZE  number of bubbles inserted since reset
// BEHAVIOUR
//  Control word layout, MSB->LSB:
//    [13] next_pc_src | [12:11] jmp_ctrl | [10] reg_write | [9:8] reg_dst
//    [7:6] mem_to_reg | [5] mem_write | [4:3] alu_src | [2:0] alu_op
//  Reset (i_reset_n=0, async): every output 0, including o_ctrl_regs=14'b0, o_valid=0 and o_bubble_count=0.
//    Release is sampled on the next rising edge.
//  Per rising edge, priority is:
//    1. i_enable=0 -> all registers, counter and o_valid hold. i_flush is ignored.
//    2. i_flush=1  -> o_ctrl_regs=14'b0 (reg_write=0, mem_write=0, next_pc_src=0), o_valid=0, o_halt=0.
//                     Data/index/field registers are zeroed.
//                     o_bubble_count increments, saturating at all-ones.
//    3. else       -> capture all inputs verbatim; o_valid=1; o_halt=i_halt.
//  Latency: exactly 1 enabled cycle from input to output; no combinational input->output paths.
//  Control-word bits are stored as presented, including X don't-cares.
//    Only flush and reset force known values.
//  Zero control word is the canonical NOP: no register write, no memory write, sequential PC.
//  o_halt is sticky only through i_enable=0.
//    A subsequent enabled, non-flush edge reloads it from i_halt.
//  Async reset asserted mid-stall or mid-flush overrides everything immediately.
//  Simultaneous i_flush=1 and i_halt=1 with enable: the bubble wins, o_halt=0.
// TESTING
//  Reset: drive i_reset_n=0 with nonzero inputs -> all outputs 0 immediately, without waiting for a clock edge.
//  Load: ADDI ctrl {0,00,1,00,00,0,01,000}, bus_a=0x5, inm=0xFFFFFFFF.
//    -> next edge o_ctrl_regs=14'b00010000001000, o_bus_a=0x5, o_inm_ext=0xFFFFFFFF, o_valid=1.
//  Stall: i_enable=0 for 3 edges while inputs change to SW ctrl -> outputs keep ADDI values.
//    Then i_enable=1 -> SW ctrl appears on the next edge.
//  Flush: i_flush=1 on an enabled edge with LW ctrl -> o_ctrl_regs=0, o_valid=0, o_bubble_count=1.
//    Same with i_enable=0 -> no change, count stays 1.
//  Saturation: CNT_SIZE=2, 5 flushes -> o_bubble_count=3.
//  Halt: i_halt=1 with i_flush=0 -> o_halt=1. Same edge with i_flush=1 -> o_halt=0, o_valid=0.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register.
// Captures the decoded control word, operand buses and instruction fields from
// the ID stage and presents them to EX one enabled cycle later. Supports a global
// hold (debug freeze), bubble insertion from the hazard unit, and a saturating
// count of inserted bubbles. Control bits pass through as presented; only reset
// and flush force known values.
module id_ex_pipeline_reg #(
  parameter int unsigned BUS_SIZE = 32,
  parameter int unsigned PC_SIZE  = 32,
  parameter int unsigned CNT_SIZE = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic                i_halt,
  input  logic [13:0]         i_ctrl_regs,
  input  logic [BUS_SIZE-1:0] i_bus_a,
  input  logic [BUS_SIZE-1:0] i_bus_b,
  input  logic [BUS_SIZE-1:0] i_inm_ext,
  input  logic [PC_SIZE-1:0]  i_next_seq_pc,
  input  logic [4:0]          i_rs,
  input  logic [4:0]          i_rt,
  input  logic [4:0]          i_rd,
  input  logic [4:0]          i_shamt,
  input  logic [5:0]          i_funct,
  output logic [13:0]         o_ctrl_regs,
  output logic [BUS_SIZE-1:0] o_bus_a,
  output logic [BUS_SIZE-1:0] o_bus_b,
  output logic [BUS_SIZE-1:0] o_inm_ext,
  output logic [PC_SIZE-1:0]  o_next_seq_pc,
  output logic [4:0]          o_rs,
  output logic [4:0]          o_rt,
  output logic [4:0]          o_rd,
  output logic [4:0]          o_shamt,
  output logic [5:0]          o_funct,
  output logic                o_valid,
  output logic                o_halt,
  output logic [CNT_SIZE-1:0] o_bubble_count
);

  // Stage register: hold when disabled, else load a bubble or the ID-stage contents
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ctrl_regs    <= '0;
      o_bus_a        <= '0;
      o_bus_b        <= '0;
      o_inm_ext      <= '0;
      o_next_seq_pc  <= '0;
      o_rs           <= '0;
      o_rt           <= '0;
      o_rd           <= '0;
      o_shamt        <= '0;
      o_funct        <= '0;
      o_valid        <= 1'b0;
      o_halt         <= 1'b0;
      o_bubble_count <= '0;
    end else if (i_enable) begin
      if (i_flush) begin
        // A zero control word is the NOP: no register/memory write, sequential PC.
        o_ctrl_regs   <= '0;
        o_bus_a       <= '0;
        o_bus_b       <= '0;
        o_inm_ext     <= '0;
        o_next_seq_pc <= '0;
        o_rs          <= '0;
        o_rt          <= '0;
        o_rd          <= '0;
        o_shamt       <= '0;
        o_funct       <= '0;
        o_valid       <= 1'b0;
        o_halt        <= 1'b0;
        if (o_bubble_count != '1) begin
          o_bubble_count <= o_bubble_count + CNT_SIZE'(1);
        end
      end else begin
        o_ctrl_regs   <= i_ctrl_regs;
        o_bus_a       <= i_bus_a;
        o_bus_b       <= i_bus_b;
        o_inm_ext     <= i_inm_ext;
        o_next_seq_pc <= i_next_seq_pc;
        o_rs          <= i_rs;
        o_rt          <= i_rt;
        o_rd          <= i_rd;
        o_shamt       <= i_shamt;
        o_funct       <= i_funct;
        o_valid       <= 1'b1;
        o_halt        <= i_halt;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed self-checking bench for id_ex_pipeline_reg.
module tb_id_ex_pipeline_reg;

  localparam logic [13:0] CTRL_ADDI = 14'b00010000001000;
  localparam logic [13:0] CTRL_SW   = 14'b00000000101000;
  localparam logic [13:0] CTRL_LW   = 14'b00010001001000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable, flush, halt;
  logic [13:0] ctrl;
  logic [31:0] bus_a, bus_b, inm, pc;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;

  logic [13:0] o_ctrl;
  logic [31:0] o_bus_a, o_bus_b, o_inm, o_pc;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_funct;
  logic        o_valid, o_halt;
  logic [15:0] o_cnt;

  logic        sat_flush;
  logic [13:0] s_ctrl;
  logic [31:0] s_bus_a, s_bus_b, s_inm, s_pc;
  logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
  logic [5:0]  s_funct;
  logic        s_valid, s_halt;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.BUS_SIZE(32), .PC_SIZE(32), .CNT_SIZE(16)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_flush(flush), .i_halt(halt),
    .i_ctrl_regs(ctrl), .i_bus_a(bus_a), .i_bus_b(bus_b), .i_inm_ext(inm),
    .i_next_seq_pc(pc), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
    .o_ctrl_regs(o_ctrl), .o_bus_a(o_bus_a), .o_bus_b(o_bus_b), .o_inm_ext(o_inm),
    .o_next_seq_pc(o_pc), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_funct(o_funct), .o_valid(o_valid), .o_halt(o_halt), .o_bubble_count(o_cnt)
  );

  id_ex_pipeline_reg #(.BUS_SIZE(32), .PC_SIZE(32), .CNT_SIZE(2)) u_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(1'b1), .i_flush(sat_flush), .i_halt(halt),
    .i_ctrl_regs(ctrl), .i_bus_a(bus_a), .i_bus_b(bus_b), .i_inm_ext(inm),
    .i_next_seq_pc(pc), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
    .o_ctrl_regs(s_ctrl), .o_bus_a(s_bus_a), .o_bus_b(s_bus_b), .o_inm_ext(s_inm),
    .o_next_seq_pc(s_pc), .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd), .o_shamt(s_shamt),
    .o_funct(s_funct), .o_valid(s_valid), .o_halt(s_halt), .o_bubble_count(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctrl"},  64'(o_ctrl),  64'h0);
    check({tag, ".bus_a"}, 64'(o_bus_a), 64'h0);
    check({tag, ".bus_b"}, 64'(o_bus_b), 64'h0);
    check({tag, ".inm"},   64'(o_inm),   64'h0);
    check({tag, ".pc"},    64'(o_pc),    64'h0);
    check({tag, ".rs"},    64'(o_rs),    64'h0);
    check({tag, ".rd"},    64'(o_rd),    64'h0);
    check({tag, ".funct"}, 64'(o_funct), 64'h0);
    check({tag, ".valid"}, 64'(o_valid), 64'h0);
    check({tag, ".halt"},  64'(o_halt),  64'h0);
    check({tag, ".cnt"},   64'(o_cnt),   64'h0);
  endtask

  task automatic drive(input logic [13:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p);
    ctrl = c; bus_a = a; bus_b = b; inm = im; pc = p;
    rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd4; funct = 6'h21;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    enable = 1'b1; flush = 1'b0; halt = 1'b1; sat_flush = 1'b0;
    drive(14'h3FFF, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h00000044);

    // Reset asserted before any clock edge
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst0");
    @(negedge clk); rst_n = 1'b1;

    // Load nonzero contents, then assert reset between edges
    step();
    check("pre.ctrl", 64'(o_ctrl), 64'h3FFF);
    check("pre.halt", 64'(o_halt), 64'h1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk); rst_n = 1'b1; halt = 1'b0;

    // ADDI load
    drive(CTRL_ADDI, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h00000104);
    step();
    check("addi.ctrl",  64'(o_ctrl),  64'(CTRL_ADDI));
    check("addi.bus_a", 64'(o_bus_a), 64'h5);
    check("addi.inm",   64'(o_inm),   64'hFFFFFFFF);
    check("addi.pc",    64'(o_pc),    64'h104);
    check("addi.rt",    64'(o_rt),    64'h2);
    check("addi.shamt", 64'(o_shamt), 64'h4);
    check("addi.funct", 64'(o_funct), 64'h21);
    check("addi.valid", 64'(o_valid), 64'h1);

    // Input change between edges must not reach the outputs
    bus_a = 32'hAAAA0000;
    #2 check("nocomb.bus_a", 64'(o_bus_a), 64'h5);

    // Stall for three edges while SW is presented
    @(negedge clk);
    enable = 1'b0;
    drive(CTRL_SW, 32'h10, 32'h77, 32'h8, 32'h108);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.ctrl",  64'(o_ctrl),  64'(CTRL_ADDI));
      check("stall.bus_a", 64'(o_bus_a), 64'h5);
    end
    @(negedge clk); enable = 1'b1;
    step();
    check("sw.ctrl",  64'(o_ctrl),  64'(CTRL_SW));
    check("sw.bus_b", 64'(o_bus_b), 64'h77);
    check("sw.valid", 64'(o_valid), 64'h1);

    // Flush with LW presented
    @(negedge clk);
    flush = 1'b1;
    drive(CTRL_LW, 32'h20, 32'h30, 32'h4, 32'h10C);
    step();
    check("flush.ctrl",  64'(o_ctrl),  64'h0);
    check("flush.valid", 64'(o_valid), 64'h0);
    check("flush.cnt",   64'(o_cnt),   64'h1);
    check("flush.bus_a", 64'(o_bus_a), 64'h0);
    check("flush.rd",    64'(o_rd),    64'h0);

    // Load LW, then flush while disabled: nothing moves
    @(negedge clk); flush = 1'b0;
    step();
    check("lw.ctrl", 64'(o_ctrl), 64'(CTRL_LW));
    @(negedge clk); flush = 1'b1; enable = 1'b0;
    step();
    check("dflush.ctrl",  64'(o_ctrl),  64'(CTRL_LW));
    check("dflush.valid", 64'(o_valid), 64'h1);
    check("dflush.cnt",   64'(o_cnt),   64'h1);

    // Halt capture, hold through stall, bubble beats halt
    @(negedge clk); flush = 1'b0; enable = 1'b1; halt = 1'b1;
    step();
    check("halt.set",   64'(o_halt),  64'h1);
    check("halt.valid", 64'(o_valid), 64'h1);
    @(negedge clk); enable = 1'b0; halt = 1'b0;
    step();
    check("halt.hold", 64'(o_halt), 64'h1);
    @(negedge clk); enable = 1'b1; halt = 1'b1; flush = 1'b1;
    step();
    check("haltflush.halt",  64'(o_halt),  64'h0);
    check("haltflush.valid", 64'(o_valid), 64'h0);
    check("haltflush.cnt",   64'(o_cnt),   64'h2);
    @(negedge clk); flush = 1'b0; halt = 1'b0;
    step();
    check("reload.halt",  64'(o_halt),  64'h0);
    check("reload.valid", 64'(o_valid), 64'h1);

    // Reset asserted mid-stall clears everything including the counter
    @(negedge clk); enable = 1'b0; flush = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_stall");
    @(negedge clk); rst_n = 1'b1; enable = 1'b1; flush = 1'b0;

    // Saturating counter on the 2-bit instance
    check("sat.start", 64'(s_cnt), 64'h0);
    @(negedge clk); sat_flush = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("sat.cnt%0d", i), 64'(s_cnt), 64'((i > 3) ? 3 : i));
    end
    check("sat.valid", 64'(s_valid), 64'h0);
    @(negedge clk); sat_flush = 1'b0;
    step();
    check("sat.keep", 64'(s_cnt), 64'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
